// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_ctrl
// Purpose  : 4x4 hex keypad scanner. Walks a one-hot column strobe and
//            samples the row lines through a two-flop synchronizer. Press and
//            release are debounced, and the key is encoded to a hex code.
//            The code is offered downstream on a valid/ack handshake, with a
//            sticky overrun flag.
// Ports    : clk       - system clock, rising edge
//            rst       - asynchronous active-high reset
//            row_in    - raw row lines (asynchronous), 1 = key closed
//            col_out   - one-hot column drive
//            key_code  - hex code of the last accepted key
//            key_valid - key_code holds an unacknowledged key
//            key_ack   - consumer takes key_code (only while key_valid=1)
//            overrun   - sticky: a key was accepted while one was pending
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 16,   // dwell cycles per column (>= 4)
    parameter int DEBOUNCE_CYC = 1000  // stable cycles to accept press/release
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);

    localparam int c_DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_DEB_W   = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DIV - 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_ONE  = c_DWELL_W'(1);
    localparam logic [c_DEB_W-1:0]   c_DEB_DONE   = c_DEB_W'(DEBOUNCE_CYC);
    localparam logic [c_DEB_W-1:0]   c_DEB_ONE    = c_DEB_W'(1);

    localparam logic [1:0] c_ST_SCAN      = 2'd0;
    localparam logic [1:0] c_ST_DEB_PRESS = 2'd1;
    localparam logic [1:0] c_ST_HELD      = 2'd2;
    localparam logic [1:0] c_ST_DEB_REL   = 2'd3;

    // Registers
    logic [3:0]           r_row_m;     // synchronizer first stage
    logic [3:0]           r_row_s;     // synchronizer second stage
    logic [3:0]           r_col;
    logic [1:0]           r_col_idx;
    logic [c_DWELL_W-1:0] r_dwell;
    logic [c_DEB_W-1:0]   r_deb;
    logic [3:0]           r_row_l;
    logic [1:0]           r_col_l;
    logic [1:0]           r_state;
    logic [3:0]           r_key_code;
    logic                 r_key_valid;
    logic                 r_overrun;

    // Combinational helpers
    logic                 w_row_match;
    logic [c_DEB_W-1:0]   w_deb_inc;
    logic                 w_deb_full;
    logic                 w_accept;
    logic                 w_ack_take;

    // Lowest-indexed pressed row wins when several rows are closed.
    function automatic logic [3:0] f_encode(input logic [3:0] row, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        r = 2'd3;
        if (row[2]) r = 2'd2;
        if (row[1]) r = 2'd1;
        if (row[0]) r = 2'd0;
        case ({r, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_row_match = (r_row_s == r_row_l);
    assign w_deb_inc   = r_deb + c_DEB_ONE;
    assign w_deb_full  = (w_deb_inc == c_DEB_DONE);
    // The edge that completes press debounce is the acceptance edge.
    assign w_accept    = (r_state == c_ST_DEB_PRESS) && w_row_match && w_deb_full;
    assign w_ack_take  = r_key_valid && key_ack;

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_m <= 4'd0;
            r_row_s <= 4'd0;
        end else begin
            r_row_m <= row_in;
            r_row_s <= r_row_m;
        end
    end

    // Scan / debounce state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_SCAN;
            r_col     <= 4'b0001;
            r_col_idx <= 2'd0;
            r_dwell   <= '0;
            r_deb     <= '0;
            r_row_l   <= 4'd0;
            r_col_l   <= 2'd0;
        end else begin
            case (r_state)
                c_ST_SCAN: begin
                    if (r_dwell == c_DWELL_LAST) begin
                        r_dwell <= '0;
                        if (r_row_s != 4'd0) begin
                            // Column stays frozen while the key is qualified.
                            r_row_l <= r_row_s;
                            r_col_l <= r_col_idx;
                            r_deb   <= '0;
                            r_state <= c_ST_DEB_PRESS;
                        end else begin
                            r_col     <= {r_col[2:0], r_col[3]};
                            r_col_idx <= r_col_idx + 2'd1;
                        end
                    end else begin
                        r_dwell <= r_dwell + c_DWELL_ONE;
                    end
                end
                c_ST_DEB_PRESS: begin
                    if (!w_row_match) begin
                        // Bounce: rescan the same column from a fresh dwell.
                        r_dwell <= '0;
                        r_state <= c_ST_SCAN;
                    end else if (w_deb_full) begin
                        r_deb   <= '0;
                        r_state <= c_ST_HELD;
                    end else begin
                        r_deb <= w_deb_inc;
                    end
                end
                c_ST_HELD: begin
                    if (r_row_s == 4'd0) begin
                        r_deb   <= '0;
                        r_state <= c_ST_DEB_REL;
                    end
                end
                default: begin // c_ST_DEB_REL
                    if (r_row_s != 4'd0) begin
                        r_deb   <= '0;
                        r_state <= c_ST_HELD;
                    end else if (w_deb_full) begin
                        r_deb     <= '0;
                        r_dwell   <= '0;
                        r_col     <= {r_col[2:0], r_col[3]};
                        r_col_idx <= r_col_idx + 2'd1;
                        r_state   <= c_ST_SCAN;
                    end else begin
                        r_deb <= w_deb_inc;
                    end
                end
            endcase
        end
    end

    // Output handshake. An acceptance with ack in the same cycle hands the
    // old code over cleanly, so it is not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_key_code <= f_encode(r_row_l, r_col_l);
            end

            if (w_accept) begin
                r_key_valid <= 1'b1;
            end else if (w_ack_take) begin
                r_key_valid <= 1'b0;
            end

            if (w_accept && r_key_valid && !key_ack) begin
                r_overrun <= 1'b1;
            end else if (w_ack_take) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign col_out   = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
